trace_readout_master: RTL

TRACE_READOUT_MASTER -- requirements
Module: trace_readout_master

---
 rtl/trace_readout_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/trace_readout_master.sv
// ---------------------------------------------------------------------------
// trace_readout_master
//
// Purpose:
//   Host-side master for a trace buffer. It takes one command (control word
//   plus word count) from the host and sends the control word to the trace
//   buffer. It then polls the status channel until the trigger bit is set,
//   and streams the requested number of data words to the host through a
//   one-entry output register that sustains one word per cycle.
//
// Ports:
//   CLK_I, RST_I                   clock, asynchronous active-high reset
//   CMD_VALID_I / CMD_READY_O      host command handshake
//   CMD_CONF_I, CMD_COUNT_I        control word, number of words to read
//   ABORT_I                        abandon current operation (ignored in idle)
//   CONTROL_VALID_O/_READY_I/_O    control word channel to trace buffer
//   STATUS_VALID_I/_READY_O/_I     status channel from trace buffer
//   DATA_VALID_I/_READY_O/_I       data channel from trace buffer
//   HOST_VALID_O/_READY_I/_DATA_O  data stream forwarded to host
//   STAT_O                         last captured status word
//   DONE_O, ABORTED_O              one-cycle completion / abort pulses
// ---------------------------------------------------------------------------
module trace_readout_master #(
  parameter int TRB_WIDTH  = 32,
  parameter int CONF_WIDTH = 32,
  parameter int STAT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TRG_BIT    = 0
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CMD_VALID_I,
  output logic                  CMD_READY_O,
  input  logic [CONF_WIDTH-1:0] CMD_CONF_I,
  input  logic [CNT_WIDTH-1:0]  CMD_COUNT_I,
  input  logic                  ABORT_I,
  output logic                  CONTROL_VALID_O,
  input  logic                  CONTROL_READY_I,
  output logic [CONF_WIDTH-1:0] CONTROL_O,
  input  logic                  STATUS_VALID_I,
  output logic                  STATUS_READY_O,
  input  logic [STAT_WIDTH-1:0] STATUS_I,
  input  logic                  DATA_VALID_I,
  output logic                  DATA_READY_O,
  input  logic [TRB_WIDTH-1:0]  DATA_I,
  output logic                  HOST_VALID_O,
  input  logic                  HOST_READY_I,
  output logic [TRB_WIDTH-1:0]  HOST_DATA_O,
  output logic [STAT_WIDTH-1:0] STAT_O,
  output logic                  DONE_O,
  output logic                  ABORTED_O
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CONF,
    S_WAIT_STAT,
    S_READ,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  // Set on every edge after reset; keeps CMD_READY_O low until the first
  // edge following reset release even though the state is already idle.
  logic                    r_live;
  logic [CONF_WIDTH-1:0]   r_conf;
  logic [CNT_WIDTH-1:0]    r_remain;
  logic                    r_host_valid;
  logic [TRB_WIDTH-1:0]    r_host_data;
  logic [STAT_WIDTH-1:0]   r_stat;
  logic                    r_aborted;

  logic w_abort;
  logic w_cmd_hs;
  logic w_ctl_hs;
  logic w_stat_hs;
  logic w_data_hs;
  logic w_host_hs;
  logic w_remain_zero;
  logic w_trig;

  assign w_abort       = ABORT_I && (r_state != S_IDLE);
  assign w_cmd_hs      = CMD_VALID_I && CMD_READY_O;
  assign w_ctl_hs      = CONTROL_VALID_O && CONTROL_READY_I;
  assign w_stat_hs     = STATUS_VALID_I && STATUS_READY_O;
  assign w_data_hs     = DATA_VALID_I && DATA_READY_O;
  assign w_host_hs     = r_host_valid && HOST_READY_I;
  assign w_remain_zero = (r_remain == '0);
  assign w_trig        = STATUS_I[TRG_BIT];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic; abort outranks every handshake
  // -------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      if (w_cmd_hs) w_next = S_SEND_CONF;
        S_SEND_CONF: if (w_ctl_hs) w_next = S_WAIT_STAT;
        S_WAIT_STAT: if (w_stat_hs && w_trig)
                       w_next = w_remain_zero ? S_DONE : S_READ;
        // Leave once every word is loaded and the output register is empty
        // or hands its last word to the host on this edge.
        S_READ:      if (w_remain_zero && (!r_host_valid || HOST_READY_I))
                       w_next = S_DONE;
        S_DONE:      w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    CMD_READY_O     = 1'b0;
    CONTROL_VALID_O = 1'b0;
    STATUS_READY_O  = 1'b0;
    DATA_READY_O    = 1'b0;
    DONE_O          = 1'b0;
    unique case (r_state)
      S_IDLE:      CMD_READY_O     = r_live;
      S_SEND_CONF: CONTROL_VALID_O = 1'b1;
      S_WAIT_STAT: STATUS_READY_O  = 1'b1;
      // Accept a word while words remain and the output register is free
      // or being drained on this same edge.
      S_READ:      DATA_READY_O    = !w_remain_zero &&
                                     (!r_host_valid || HOST_READY_I);
      S_DONE:      DONE_O          = 1'b1;
      default:     ;
    endcase
  end

  assign CONTROL_O   = r_conf;
  assign HOST_VALID_O = r_host_valid;
  assign HOST_DATA_O = r_host_data;
  assign STAT_O      = r_stat;
  assign ABORTED_O   = r_aborted;

  // -------------------------------------------------------------------------
  // Datapath: command capture, status capture, output register, word count
  // -------------------------------------------------------------------------
  // NOTE: the data registers are reset as well as the control state, since
  // CONTROL_O, HOST_DATA_O and STAT_O must read zero while reset is held.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_live       <= 1'b0;
      r_conf       <= '0;
      r_remain     <= '0;
      r_host_valid <= 1'b0;
      r_host_data  <= '0;
      r_stat       <= '0;
      r_aborted    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_aborted <= w_abort;

      if (w_cmd_hs) r_conf <= CMD_CONF_I;

      if (w_stat_hs && !w_abort) r_stat <= STATUS_I;

      // Command handshake happens only in idle, where abort is ignored, so
      // the two never collide. DATA_READY_O is low at zero remaining words,
      // so the decrement cannot wrap.
      if (w_cmd_hs) begin
        r_remain <= CMD_COUNT_I;
      end else if (w_abort) begin
        r_host_valid <= 1'b0;
        r_remain     <= '0;
      end else if (w_data_hs) begin
        r_host_valid <= 1'b1;
        r_host_data  <= DATA_I;
        r_remain     <= r_remain - CNT_WIDTH'(1);
      end else if (w_host_hs) begin
        r_host_valid <= 1'b0;
      end
    end
  end

endmodule
